// File: rtl/sr_pkg.sv
// sr_pkg
//   Shared types and constants for the SR flip-flop drive sequencer.
//   sr_state_e : sequencer FSM states (IDLE, PULSE, GAP, CHECK)
//   LVL_SET    : commanded level that drives s
//   LVL_RST    : commanded level that drives r
//   max2       : elaboration-time helper for sizing the shared timer
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } sr_state_e;

  localparam logic LVL_SET = 1'b1;
  localparam logic LVL_RST = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_flip_flop.sv
// sr_flip_flop
//   Clocked SR storage cell: s sets q, r clears q, neither holds.
//   s=r=1 is never driven by the sequencer; r takes priority here only
//   so the cell has a defined behaviour.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (q -> 0)
//   s      in   set
//   r      in   reset
//   q      out  stored level
module sr_flip_flop (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    if (r)      q_d = 1'b0;
    else if (s) q_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer
//   Turns target-level requests into timed, non-overlapping set/reset
//   pulses for one SR flip-flop and tracks the commanded level.
//   Optional readback check is compiled in with SR_DRIVE_READBACK_EN.
// Parameters:
//   PULSE_W  cycles s or r is held high per command (>= 1)
//   GAP_W    dead cycles with s=r=0 after each pulse (>= 0)
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_level  in   requested level (1 = set, 0 = reset)
//   req_ready  out  request can be accepted
//   s, r       out  registered set/reset drives
//   busy       out  pulse/gap/check in progress
//   cur_level  out  last commanded level
//   q_fb       in   flip-flop q readback (readback build only)
//   err_clr    in   clears err (readback build only)
//   err        out  sticky readback mismatch (0 without readback)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | ready for a request; no-change requests are absorbed here
// PULSE | s or r high for PULSE_W cycles
// GAP   | s=r=0 dead time for GAP_W cycles
// CHECK | one cycle comparing q_fb to cur_level (readback build)
module sr_drive_sequencer
  import sr_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic busy,
  output logic cur_level,
  input  logic q_fb,
  input  logic err_clr,
  output logic err
);

  localparam int CNT_MAX = max2(PULSE_W, GAP_W);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

`ifdef SR_DRIVE_READBACK_EN
  localparam sr_state_e AFTER_DEAD = CHECK;
`else
  localparam sr_state_e AFTER_DEAD = IDLE;
`endif

  sr_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             cur_level_d, cur_level_q;
  logic             s_d, s_q;
  logic             r_d, r_q;
  logic             busy_d, busy_q;
`ifdef SR_DRIVE_READBACK_EN
  logic             err_d, err_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_level_d = cur_level_q;

    case (state_q)
      IDLE: begin
        // A request for the level already held completes here with no pulse.
        if (req_valid && (req_level != cur_level_q)) begin
          cur_level_d = req_level;
          cnt_d       = PULSE_LD;
          state_d     = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (GAP_W > 0) begin
            cnt_d   = GAP_LD;
            state_d = GAP;
          end else begin
            state_d = AFTER_DEAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = AFTER_DEAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are clean flops;
    // s and r come from opposite values of one bit and cannot both be 1.
    s_d    = (state_d == PULSE) && (cur_level_d == LVL_SET);
    r_d    = (state_d == PULSE) && (cur_level_d == LVL_RST);
    busy_d = (state_d != IDLE);
  end

`ifdef SR_DRIVE_READBACK_EN
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    // A mismatch in the same cycle as a clear must not be lost.
    if ((state_q == CHECK) && (q_fb != cur_level_q)) err_d = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_level_q <= LVL_RST;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SR_DRIVE_READBACK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_level_q <= cur_level_d;
      s_q         <= s_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
`ifdef SR_DRIVE_READBACK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign req_ready = ~busy_q;
  assign cur_level = cur_level_q;

`ifdef SR_DRIVE_READBACK_EN
  assign err = err_q;
`else
  logic unused_inputs;
  assign unused_inputs = q_fb ^ err_clr;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_drive_sequencer.sv
module tb_sr_drive_sequencer;

`ifdef SR_DRIVE_READBACK_EN
  localparam int TURN   = 4;
  localparam int M_TURN = 2;
`else
  localparam int TURN   = 3;
  localparam int M_TURN = 1;
`endif

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_level, req_ready, s, r, busy, cur_level, q_fb, err_clr, err;
  logic ff_q, fb_force, fb_val;
  logic m_req_valid, m_req_level, m_req_ready, m_s, m_r, m_busy, m_cur_level, m_err, m_ff_q;
  logic m_err_clr;

  always #5 clk = ~clk;

  assign q_fb = fb_force ? fb_val : ff_q;

  sr_drive_sequencer #(.PULSE_W(2), .GAP_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
    .req_ready(req_ready), .s(s), .r(r), .busy(busy), .cur_level(cur_level),
    .q_fb(q_fb), .err_clr(err_clr), .err(err)
  );
  sr_flip_flop ff (.clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(ff_q));

  sr_drive_sequencer #(.PULSE_W(1), .GAP_W(0)) dut_min (
    .clk(clk), .rst_n(rst_n), .req_valid(m_req_valid), .req_level(m_req_level),
    .req_ready(m_req_ready), .s(m_s), .r(m_r), .busy(m_busy), .cur_level(m_cur_level),
    .q_fb(m_ff_q), .err_clr(m_err_clr), .err(m_err)
  );
  sr_flip_flop ff_min (.clk(clk), .rst_n(rst_n), .s(m_s), .r(m_r), .q(m_ff_q));

  task automatic do_reset();
    req_valid = 1'b0; m_req_valid = 1'b0; fb_force = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 1'b0; req_level = 1'b0; err_clr = 1'b0;
    fb_force = 1'b0; fb_val = 1'b0;
    m_req_valid = 1'b0; m_req_level = 1'b0; m_err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL reset_s: got %b expected 0", s); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL reset_r: got %b expected 0", r); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cur_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", cur_level); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL reset_min_ready: got %b expected 1", m_req_ready); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Set from reset state: s for 2 cycles, ready back after TURN edges.
  task automatic test_set();
    logic exp_s, exp_rdy;
    req_level = 1'b1; req_valid = 1'b1;
    for (int k = 0; k <= TURN; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = 1'b0;
      exp_s   = (k < 2);
      exp_rdy = (k >= TURN);
      checks++; if (s !== exp_s) begin errors++; $display("FAIL set_s k=%0d: got %b expected %b", k, s, exp_s); end
      checks++; if (r !== 1'b0) begin errors++; $display("FAIL set_r k=%0d: got %b expected 0", k, r); end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL set_ready k=%0d: got %b expected %b", k, req_ready, exp_rdy); end
      checks++; if (busy !== ~exp_rdy) begin errors++; $display("FAIL set_busy k=%0d: got %b expected %b", k, busy, ~exp_rdy); end
    end
    checks++; if (cur_level !== 1'b1) begin errors++; $display("FAIL set_level: got %b expected 1", cur_level); end
    checks++; if (ff_q !== 1'b1) begin errors++; $display("FAIL set_ff_q: got %b expected 1", ff_q); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL set_err: got %b expected 0", err); end
  endtask

  task automatic test_redundant();
    req_level = 1'b1; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL redund_ready k=%0d: got %b expected 1", k, req_ready); end
      checks++; if ((s | r | busy) !== 1'b0) begin errors++; $display("FAIL redund_activity k=%0d: got s=%b r=%b busy=%b expected all 0", k, s, r, busy); end
      checks++; if (cur_level !== 1'b1) begin errors++; $display("FAIL redund_level k=%0d: got %b expected 1", k, cur_level); end
    end
    req_valid = 1'b0;
  endtask

  // Set then reset with req_valid held; second accept waits for ready.
  task automatic test_back_to_back();
    logic exp_s, exp_r;
    do_reset();
    req_level = 1'b1; req_valid = 1'b1;
    for (int k = 0; k <= 2 * TURN + 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_level = 1'b0;
      if (k == TURN + 1) req_valid = 1'b0;
      exp_s = (k < 2);
      exp_r = (k == TURN + 1) || (k == TURN + 2);
      checks++; if (s !== exp_s) begin errors++; $display("FAIL b2b_s k=%0d: got %b expected %b", k, s, exp_s); end
      checks++; if (r !== exp_r) begin errors++; $display("FAIL b2b_r k=%0d: got %b expected %b", k, r, exp_r); end
      checks++; if ((s & r) !== 1'b0) begin errors++; $display("FAIL b2b_overlap k=%0d: got s&r=%b expected 0", k, s & r); end
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
    checks++; if (cur_level !== 1'b0) begin errors++; $display("FAIL b2b_level: got %b expected 0", cur_level); end
    checks++; if (ff_q !== 1'b0) begin errors++; $display("FAIL b2b_ff_q: got %b expected 0", ff_q); end
  endtask

`ifdef SR_DRIVE_READBACK_EN
  task automatic test_readback();
    logic exp_e;
    do_reset();
    fb_force = 1'b1; fb_val = 1'b0;
    req_level = 1'b1; req_valid = 1'b1;
    for (int k = 0; k <= TURN + 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = 1'b0;
      exp_e = (k >= TURN);
      checks++; if (err !== exp_e) begin errors++; $display("FAIL rb_err k=%0d: got %b expected %b", k, err, exp_e); end
    end
    fb_force = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rb_clear: got %b expected 0", err); end
    // Mismatch on the way back to 0 with err_clr asserted during CHECK.
    fb_force = 1'b1; fb_val = 1'b1;
    req_level = 1'b0; req_valid = 1'b1;
    for (int k = 0; k <= TURN; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = 1'b0;
      if (k == TURN - 1) begin
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rb_pre_set: got %b expected 0", err); end
        err_clr = 1'b1;
      end
      if (k == TURN) begin
        err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rb_set_wins: got %b expected 1", err); end
      end
    end
    fb_force = 1'b0;
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rb_sticky: got %b expected 1", err); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rb_clear2: got %b expected 0", err); end
  endtask
`else
  task automatic test_readback();
    do_reset();
    fb_force = 1'b1; fb_val = 1'b0;
    req_level = 1'b1; req_valid = 1'b1;
    for (int k = 0; k <= TURN + 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rb_off_err k=%0d: got %b expected 0", k, err); end
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rb_off_ready: got %b expected 1", req_ready); end
    fb_force = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_pulse();
    logic exp_s;
    do_reset();
    req_level = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL mid_first_pulse: got %b expected 1", s); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL mid_s_drop: got %b expected 0", s); end
    checks++; if (cur_level !== 1'b0) begin errors++; $display("FAIL mid_level: got %b expected 0", cur_level); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    req_level = 1'b1; req_valid = 1'b1;
    for (int k = 0; k <= 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) req_valid = 1'b0;
      exp_s = (k < 2);
      checks++; if (s !== exp_s) begin errors++; $display("FAIL mid_repulse_s k=%0d: got %b expected %b", k, s, exp_s); end
    end
    checks++; if (cur_level !== 1'b1) begin errors++; $display("FAIL mid_repulse_level: got %b expected 1", cur_level); end
    repeat (TURN) @(posedge clk);
    #1;
  endtask

  task automatic test_minimal();
    logic exp_rdy;
    do_reset();
    for (int lv = 1; lv >= 0; lv--) begin
      m_req_level = lv[0]; m_req_valid = 1'b1;
      for (int k = 0; k <= M_TURN; k++) begin
        @(posedge clk); #1;
        if (k == 0) m_req_valid = 1'b0;
        exp_rdy = (k >= M_TURN);
        checks++; if (m_s !== ((k == 0) && lv == 1)) begin errors++; $display("FAIL min_s lv=%0d k=%0d: got %b", lv, k, m_s); end
        checks++; if (m_r !== ((k == 0) && lv == 0)) begin errors++; $display("FAIL min_r lv=%0d k=%0d: got %b", lv, k, m_r); end
        checks++; if (m_req_ready !== exp_rdy) begin errors++; $display("FAIL min_ready lv=%0d k=%0d: got %b expected %b", lv, k, m_req_ready, exp_rdy); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL min_err lv=%0d k=%0d: got %b expected 0", lv, k, m_err); end
      end
      checks++; if (m_cur_level !== lv[0]) begin errors++; $display("FAIL min_level lv=%0d: got %b", lv, m_cur_level); end
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_redundant();
    test_back_to_back();
    test_readback();
    test_reset_mid_pulse();
    test_minimal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
